// File: rtl/spi_master_fifo.sv
// SPI master with TX/RX FIFOs behind an Avalon-MM register slave.
// Runtime CPOL/CPHA/bit order, half-period divider, up to 16 selects, level irq.
module spi_master_fifo #(
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_SLAVES  = 1,
   parameter int FIFO_DEPTH  = 4,
   parameter int DIV_WIDTH   = 12,
   parameter int DEFAULT_DIV = 1249
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            address,
   input  logic                  read,
   input  logic                  write,
   input  logic [15:0]           writedata,
   output logic [15:0]           readdata,
   output logic                  irq,
   output logic                  SCLK,
   output logic                  MOSI,
   input  logic                  MISO,
   output logic [NUM_SLAVES-1:0] SS_n
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [5:0]    LAST_EDGE = 6'(2 * DATA_WIDTH);
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

   function automatic logic out_bit(input logic [DATA_WIDTH-1:0] v, input logic lsb);
      return lsb ? v[0] : v[DATA_WIDTH-1];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v,
                                                       input logic lsb);
      return lsb ? (v >> 1) : (v << 1);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] v,
                                                      input logic lsb, input logic b);
      return lsb ? {b, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], b};
   endfunction

   // Register file
   logic [7:0]            ctrl_q;
   logic [DIV_WIDTH-1:0]  div_q;
   logic [NUM_SLAVES-1:0] mask_q;
   logic                  toe_q, roe_q, irq_q;
   logic [15:0]           readdata_q, rd_d, status;
   logic                  sso, lsbf, cpha, cpol;
   logic                  unused_ok;

   // FIFOs
   logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
   logic [AW-1:0]         tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
   logic [CW-1:0]         tx_cnt_q, rx_cnt_q;
   logic                  tx_empty, tx_full, rx_empty, rx_full;
   logic                  tx_wr, tx_push, tx_pop, rx_push, rx_acc, rx_pop;
   logic [DATA_WIDTH-1:0] tx_head;

   // Shifter
   state_t                state_q;
   logic [DIV_WIDTH-1:0]  cnt_q, div_s_q;
   logic [5:0]            ecnt_q;
   logic [DATA_WIDTH-1:0] sh_q, rx_sh_q, sh_nx;
   logic                  sclk_q, mosi_q;
   logic [NUM_SLAVES-1:0] ss_n_q, mask_s_q;
   logic                  cpol_s_q, cpha_s_q, lsb_s_q;
   logic                  tick, do_edge, busy, tmt;

   assign {sso, lsbf, cpha, cpol} = ctrl_q[7:4];
   assign unused_ok = &{1'b0, writedata};

   assign tx_empty = (tx_cnt_q == '0);
   assign tx_full  = (tx_cnt_q == FULL_CNT);
   assign rx_empty = (rx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == FULL_CNT);
   assign tx_head  = tx_mem[tx_rp_q];

   assign tick    = (state_q != IDLE) && (cnt_q == div_s_q);
   assign do_edge = tick && ((state_q == LEAD) || (state_q == SHIFT && ecnt_q != LAST_EDGE));
   assign sh_nx   = shift_out(sh_q, lsb_s_q);

   // A full FIFO still accepts a push when the same cycle pops it.
   assign tx_wr   = write && (address == 3'd1);
   assign tx_pop  = !tx_empty && ((state_q == IDLE) || (state_q == TRAIL && tick));
   assign tx_push = tx_wr && (!tx_full || tx_pop);
   assign rx_pop  = read && (address == 3'd0) && !rx_empty;
   assign rx_push = (state_q == TRAIL) && tick;
   assign rx_acc  = rx_push && (!rx_full || rx_pop);

   assign busy   = (state_q != IDLE);
   assign tmt    = tx_empty && !busy;
   assign status = {6'(tx_cnt_q), busy, toe_q | roe_q, !rx_empty, !tx_full, tmt,
                    toe_q, roe_q, 3'b000};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_wp_q <= '0; tx_rp_q <= '0; tx_cnt_q <= '0;
         rx_wp_q <= '0; rx_rp_q <= '0; rx_cnt_q <= '0;
      end else begin
         if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
         if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
         tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
         if (rx_acc)  rx_wp_q <= rx_wp_q + 1'b1;
         if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
         rx_cnt_q <= rx_cnt_q + CW'(rx_acc) - CW'(rx_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp_q] <= writedata[DATA_WIDTH-1:0];
      if (rx_acc)  rx_mem[rx_wp_q] <= rx_sh_q;
   end

   always_comb begin
      rd_d = '0;
      case (address)
         3'd0:    rd_d = rx_empty ? 16'h0 : 16'(rx_mem[rx_rp_q]);
         3'd2:    rd_d = status;
         3'd3:    rd_d = {5'b0, ctrl_q, 3'b000};
         3'd4:    rd_d = 16'(div_q);
         3'd5:    rd_d = 16'(mask_q);
         default: rd_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q     <= '0;
         div_q      <= DIV_WIDTH'(DEFAULT_DIV);
         mask_q     <= NUM_SLAVES'(1);
         toe_q      <= 1'b0;
         roe_q      <= 1'b0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         if (write && address == 3'd3) ctrl_q <= writedata[10:3];
         if (write && address == 3'd4) div_q  <= writedata[DIV_WIDTH-1:0];
         if (write && address == 3'd5) mask_q <= writedata[NUM_SLAVES-1:0];
         if (write && address == 3'd2) begin
            toe_q <= 1'b0;
            roe_q <= 1'b0;
         end
         // A new overflow in the clearing cycle is not lost.
         if (tx_wr && !tx_push)  toe_q <= 1'b1;
         if (rx_push && !rx_acc) roe_q <= 1'b1;
         if (read) readdata_q <= rd_d;
         irq_q <= (!rx_empty & ctrl_q[3]) | (!tx_full & ctrl_q[2]) |
                  (tmt & ctrl_q[1]) | ((toe_q | roe_q) & ctrl_q[0]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ecnt_q   <= '0;
         sh_q     <= '0;
         rx_sh_q  <= '0;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         ss_n_q   <= '1;
         cpol_s_q <= 1'b0;
         cpha_s_q <= 1'b0;
         lsb_s_q  <= 1'b0;
         div_s_q  <= DIV_WIDTH'(DEFAULT_DIV);
         mask_s_q <= NUM_SLAVES'(1);
      end else begin
         if (state_q != IDLE) cnt_q <= tick ? '0 : cnt_q + 1'b1;
         case (state_q)
            IDLE: begin
               sclk_q <= cpol;
               ss_n_q <= sso ? ~mask_q : '1;
               if (!tx_empty) begin
                  state_q  <= LEAD;
                  cnt_q    <= '0;
                  ecnt_q   <= '0;
                  cpol_s_q <= cpol;
                  cpha_s_q <= cpha;
                  lsb_s_q  <= lsbf;
                  div_s_q  <= div_q;
                  mask_s_q <= mask_q;
                  sh_q     <= tx_head;
                  mosi_q   <= out_bit(tx_head, lsbf);
                  ss_n_q   <= ~mask_q;
               end
            end
            LEAD:  if (tick) state_q <= SHIFT;
            SHIFT: if (tick && ecnt_q == LAST_EDGE) state_q <= TRAIL;
            TRAIL: if (tick) begin
               if (!tx_empty) begin
                  state_q <= LEAD;
                  ecnt_q  <= '0;
                  sh_q    <= tx_head;
                  mosi_q  <= out_bit(tx_head, lsb_s_q);
                  ss_n_q  <= ~mask_s_q;
               end else begin
                  state_q <= IDLE;
                  ss_n_q  <= sso ? ~mask_q : '1;
               end
            end
            default: state_q <= IDLE;
         endcase
         // The LEAD-exit tick produces edge 1; edges alternate leading/trailing.
         if (do_edge) begin
            sclk_q <= ~sclk_q;
            ecnt_q <= ecnt_q + 1'b1;
            if (ecnt_q[0] == cpha_s_q) begin
               rx_sh_q <= shift_in(rx_sh_q, lsb_s_q, MISO);
            end else if (cpha_s_q) begin
               mosi_q <= out_bit(sh_q, lsb_s_q);
               sh_q   <= sh_nx;
            end else begin
               mosi_q <= out_bit(sh_nx, lsb_s_q);
               sh_q   <= sh_nx;
            end
         end
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;
   assign SCLK     = sclk_q;
   assign MOSI     = mosi_q;
   assign SS_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo: MISO looped back to MOSI, SPI lines
// watched at the falling clk edge, bus driven between edges.
module tb_spi_master_fifo;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  address = '0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [15:0] writedata = '0;
   logic [15:0] readdata;
   logic        irq, SCLK, MOSI, MISO;
   logic [0:0]  SS_n;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;
   assign MISO = MOSI;

   spi_master_fifo #(.DATA_WIDTH(8), .NUM_SLAVES(1), .FIFO_DEPTH(4),
                     .DIV_WIDTH(12), .DEFAULT_DIV(1249)) dut (
      .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
      .writedata(writedata), .readdata(readdata), .irq(irq), .SCLK(SCLK),
      .MOSI(MOSI), .MISO(MISO), .SS_n(SS_n));

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      address = a; writedata = d; write = 1'b1;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
      @(negedge clk);
      address = a; read = 1'b1;
      @(negedge clk);
      read = 1'b0;
      d = readdata;
   endtask

   // Records MOSI on every SCLK rise while SS_n is low, until SS_n deasserts.
   task automatic capture(input int maxcyc, output int rises, output logic [63:0] bits,
                          output int lead, output int pmin, output int pmax, output bit tmo);
      logic prev;
      bit   seen;
      int   last;
      rises = 0; bits = '0; lead = 0; pmin = 100000; pmax = 0; tmo = 1'b1;
      seen = 1'b0; last = 0; prev = SCLK;
      for (int c = 0; c < maxcyc; c++) begin
         @(negedge clk);
         if (SS_n[0] == 1'b0) seen = 1'b1;
         if (seen && SS_n[0] == 1'b1) begin
            tmo = 1'b0;
            break;
         end
         if (seen && SCLK && !prev) begin
            if (rises > 0) begin
               if (c - last < pmin) pmin = c - last;
               if (c - last > pmax) pmax = c - last;
            end
            last = c;
            rises++;
            bits = {bits[62:0], MOSI};
         end
         if (seen && rises == 0) lead++;
         prev = SCLK;
      end
   endtask

   task automatic test_reset();
      logic [15:0] d;
      do_reset();
      checks++; if (readdata !== 16'h0) begin errors++; $display("FAIL rst_readdata got %h want 0000", readdata); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b want 0", irq); end
      checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL rst_ss_n got %b want 1", SS_n); end
      checks++; if (SCLK !== 1'b0) begin errors++; $display("FAIL rst_sclk got %b want 0", SCLK); end
      checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b want 0", MOSI); end
      bus_read(3'd2, d);
      checks++; if (d !== 16'h0060) begin errors++; $display("FAIL rst_status got %h want 0060", d); end
      bus_read(3'd3, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rst_control got %h want 0000", d); end
      bus_read(3'd4, d);
      checks++; if (d !== 16'd1249) begin errors++; $display("FAIL rst_divider got %0d want 1249", d); end
      bus_read(3'd5, d);
      checks++; if (d !== 16'h0001) begin errors++; $display("FAIL rst_mask got %h want 0001", d); end
      bus_read(3'd7, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL addr7 got %h want 0000", d); end
      bus_read(3'd0, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL empty_rx got %h want 0000", d); end
      bus_read(3'd2, d);
      checks++; if (d !== 16'h0060) begin errors++; $display("FAIL empty_rx_status got %h want 0060", d); end
   endtask

   task automatic test_mode0();
      int rises, lead, pmin, pmax;
      logic [63:0] bits;
      bit tmo;
      logic [15:0] d;
      do_reset();
      bus_write(3'd4, 16'd1);
      fork
         bus_write(3'd1, 16'h00A5);
         capture(400, rises, bits, lead, pmin, pmax, tmo);
      join
      checks++; if (tmo) begin errors++; $display("FAIL m0_timeout got 1 want 0"); end
      checks++; if (rises != 8) begin errors++; $display("FAIL m0_rises got %0d want 8", rises); end
      checks++; if (lead != 2) begin errors++; $display("FAIL m0_lead got %0d want 2", lead); end
      checks++; if (pmin != 4 || pmax != 4) begin errors++; $display("FAIL m0_period got %0d..%0d want 4", pmin, pmax); end
      checks++; if (bits[7:0] !== 8'hA5) begin errors++; $display("FAIL m0_mosi got %h want a5", bits[7:0]); end
      checks++; if (SCLK !== 1'b0) begin errors++; $display("FAIL m0_sclk_idle got %b want 0", SCLK); end
      bus_read(3'd0, d);
      checks++; if (d !== 16'h00A5) begin errors++; $display("FAIL m0_rx got %h want 00a5", d); end
      bus_read(3'd2, d);
      checks++; if (d !== 16'h0060) begin errors++; $display("FAIL m0_status got %h want 0060", d); end
   endtask

   task automatic test_div0();
      int rises, lead, pmin, pmax;
      logic [63:0] bits;
      bit tmo;
      logic [15:0] d;
      do_reset();
      bus_write(3'd4, 16'd0);
      fork
         bus_write(3'd1, 16'h005A);
         capture(200, rises, bits, lead, pmin, pmax, tmo);
      join
      checks++; if (tmo || rises != 8) begin errors++; $display("FAIL d0_rises got %0d tmo %0d want 8", rises, tmo); end
      checks++; if (pmin != 2 || pmax != 2) begin errors++; $display("FAIL d0_period got %0d..%0d want 2", pmin, pmax); end
      checks++; if (lead != 1) begin errors++; $display("FAIL d0_lead got %0d want 1", lead); end
      checks++; if (bits[7:0] !== 8'h5A) begin errors++; $display("FAIL d0_mosi got %h want 5a", bits[7:0]); end
      bus_read(3'd0, d);
      checks++; if (d !== 16'h005A) begin errors++; $display("FAIL d0_rx got %h want 005a", d); end
   endtask

   task automatic test_back_to_back();
      int rises, lead, pmin, pmax;
      logic [63:0] bits;
      bit tmo;
      logic [15:0] d;
      logic [7:0] exp_w [4];
      exp_w = '{8'h3C, 8'hC3, 8'h0F, 8'hF0};
      do_reset();
      bus_write(3'd4, 16'd1);
      fork
         for (int i = 0; i < 4; i++) bus_write(3'd1, {8'h00, exp_w[i]});
         capture(1000, rises, bits, lead, pmin, pmax, tmo);
      join
      checks++; if (tmo || rises != 32) begin errors++; $display("FAIL b2b_ss_held rises %0d tmo %0d want 32", rises, tmo); end
      checks++; if (bits[31:0] !== 32'h3CC30FF0) begin errors++; $display("FAIL b2b_mosi got %h want 3cc30ff0", bits[31:0]); end
      for (int i = 0; i < 4; i++) begin
         bus_read(3'd0, d);
         checks++; if (d !== {8'h00, exp_w[i]}) begin errors++; $display("FAIL b2b_rx%0d got %h want %h", i, d, exp_w[i]); end
      end
      bus_read(3'd2, d);
      checks++; if (d !== 16'h0060) begin errors++; $display("FAIL b2b_status got %h want 0060", d); end
   endtask

   task automatic test_overflow();
      logic [15:0] d;
      do_reset();
      bus_write(3'd4, 16'd3);
      bus_write(3'd3, 16'h0008);
      for (int i = 0; i < 6; i++) bus_write(3'd1, 16'(i + 16));
      bus_read(3'd2, d);
      checks++; if (d !== 16'h1310) begin errors++; $display("FAIL ovf_status got %h want 1310", d); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ovf_irq got %b want 1", irq); end
      bus_write(3'd2, 16'h0000);
      @(negedge clk);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ovf_irq_clr got %b want 0", irq); end
      bus_read(3'd2, d);
      checks++; if (d !== 16'h1200) begin errors++; $display("FAIL ovf_status_clr got %h want 1200", d); end
   endtask

   task automatic test_mode3_roe();
      int rises, lead, pmin, pmax;
      logic [63:0] bits;
      bit tmo;
      logic [15:0] d;
      do_reset();
      bus_write(3'd4, 16'd1);
      bus_write(3'd3, 16'h0380);
      @(negedge clk);
      checks++; if (SCLK !== 1'b1) begin errors++; $display("FAIL m3_sclk_idle got %b want 1", SCLK); end
      fork
         for (int i = 0; i < 5; i++) bus_write(3'd1, 16'h0001);
         capture(1500, rises, bits, lead, pmin, pmax, tmo);
      join
      checks++; if (tmo || rises != 40) begin errors++; $display("FAIL m3_rises got %0d tmo %0d want 40", rises, tmo); end
      checks++; if (bits[39:0] !== 40'h8080808080) begin errors++; $display("FAIL m3_mosi got %h want 8080808080", bits[39:0]); end
      checks++; if (SCLK !== 1'b1) begin errors++; $display("FAIL m3_sclk_end got %b want 1", SCLK); end
      bus_read(3'd2, d);
      checks++; if (d !== 16'h01E8) begin errors++; $display("FAIL m3_status got %h want 01e8", d); end
      for (int i = 0; i < 4; i++) begin
         bus_read(3'd0, d);
         checks++; if (d !== 16'h0001) begin errors++; $display("FAIL m3_rx%0d got %h want 0001", i, d); end
      end
      bus_read(3'd0, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL m3_rx_empty got %h want 0000", d); end
      bus_read(3'd2, d);
      checks++; if (d !== 16'h0168) begin errors++; $display("FAIL m3_status_end got %h want 0168", d); end
   endtask

   task automatic test_reset_mid();
      int r;
      logic p;
      bit hit;
      logic [15:0] d;
      do_reset();
      bus_write(3'd4, 16'd1);
      r = 0; hit = 1'b0;
      fork
         begin
            bus_write(3'd1, 16'h0011);
            bus_write(3'd1, 16'h0022);
         end
         begin
            p = SCLK;
            for (int c = 0; c < 400 && !hit; c++) begin
               @(negedge clk);
               if (SCLK && !p) r++;
               p = SCLK;
               if (r == 9) hit = 1'b1;
            end
         end
      join
      checks++; if (!hit) begin errors++; $display("FAIL mid_word2 rises %0d want 9", r); end
      reset = 1'b1;
      #1;
      checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL mid_ss_n got %b want 1", SS_n); end
      checks++; if (SCLK !== 1'b0) begin errors++; $display("FAIL mid_sclk got %b want 0", SCLK); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      bus_read(3'd2, d);
      checks++; if (d !== 16'h0060) begin errors++; $display("FAIL mid_status got %h want 0060", d); end
      bus_read(3'd0, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL mid_rx got %h want 0000", d); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_mode0();
      test_div0();
      test_back_to_back();
      test_overflow();
      test_mode3_roe();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
